// File: rtl/ex_ic_arbiter.sv
// Per-FU completion queues feeding a round-robin, single-port arbiter that
// registers one EX_IC_PACKET per cycle for the issue-complete stage.

package ex_ic_pkg;

  typedef struct packed {
    logic [5:0] phys_reg;
  } dest_tag_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rob_idx;
    dest_tag_t  dest_tag;
    logic [31:0] result;
    logic       take_branch;
  } ex_ic_packet_t;

  localparam int PKT_W = $bits(ex_ic_packet_t);

endpackage

module ex_ic_arbiter
  import ex_ic_pkg::*;
#(
  parameter int N_FU       = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_FU-1:0]       fu_valid,
  input  logic [N_FU*PKT_W-1:0] fu_packet,
  output logic [N_FU-1:0]       fu_ready,
  input  logic                  squash,
  output logic [PKT_W-1:0]      ex_ic_reg,
  output logic                  ic_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [AW-1:0] head_q  [N_FU];
  logic [AW-1:0] head_d  [N_FU];
  logic [AW-1:0] tail_q  [N_FU];
  logic [AW-1:0] tail_d  [N_FU];
  logic [CW-1:0] count_q [N_FU];
  logic [CW-1:0] count_d [N_FU];
  logic [RW-1:0] rr_ptr_q, rr_ptr_d;
  ex_ic_packet_t ex_ic_q, ex_ic_d;

  ex_ic_packet_t fifo_mem [N_FU][FIFO_DEPTH];

  logic [N_FU-1:0] push_en;
  logic [N_FU-1:0] pop_en;
  logic            found;
  logic [RW-1:0]   win;

  // Ready looks only at registered occupancy, so a same-cycle pop never
  // frees a slot for a same-cycle push.
  always_comb begin
    for (int i = 0; i < N_FU; i++) begin
      fu_ready[i] = reset_n && (count_q[i] != CW'(FIFO_DEPTH));
      push_en[i]  = fu_valid[i] && fu_ready[i] && !squash;
    end
  end

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    logic [RW:0] cand;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_FU; k++) begin
      cand = {1'b0, rr_ptr_q} + (RW+1)'(k);
      if (cand >= (RW+1)'(N_FU)) cand = cand - (RW+1)'(N_FU);
      if (!found && (count_q[cand[RW-1:0]] != '0)) begin
        found = 1'b1;
        win   = cand[RW-1:0];
      end
    end
  end

  always_comb begin
    ex_ic_d  = '0;
    rr_ptr_d = rr_ptr_q;
    pop_en   = '0;
    for (int i = 0; i < N_FU; i++) begin
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
      count_d[i] = count_q[i];
    end

    if (squash) begin
      rr_ptr_d = '0;
      for (int i = 0; i < N_FU; i++) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end
    end else begin
      if (found) begin
        ex_ic_d       = fifo_mem[win][head_q[win]];
        ex_ic_d.valid = 1'b1;
        pop_en[win]   = 1'b1;
        rr_ptr_d      = (win == RW'(N_FU - 1)) ? '0 : win + 1'b1;
      end
      // Depth is a power of two, so pointer wrap is the natural AW-bit overflow.
      for (int i = 0; i < N_FU; i++) begin
        if (push_en[i]) tail_d[i] = tail_q[i] + 1'b1;
        if (pop_en[i])  head_d[i] = head_q[i] + 1'b1;
        count_d[i] = count_q[i] + CW'(push_en[i]) - CW'(pop_en[i]);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      ex_ic_q  <= '0;
      for (int i = 0; i < N_FU; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ex_ic_q  <= ex_ic_d;
      for (int i = 0; i < N_FU; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; counts gate every read,
  // so stale contents are never observable.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_FU; i++) begin
      if (push_en[i]) fifo_mem[i][tail_q[i]] <= ex_ic_packet_t'(fu_packet[i*PKT_W +: PKT_W]);
    end
  end

  always_comb begin
    ic_busy = ex_ic_q.valid;
    for (int i = 0; i < N_FU; i++) begin
      if (count_q[i] != '0) ic_busy = 1'b1;
    end
  end

  assign ex_ic_reg = ex_ic_q;

endmodule

// File: tb/tb_ex_ic_arbiter.sv
// Bench for ex_ic_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.

module tb_ex_ic_arbiter;
  import ex_ic_pkg::*;

  localparam int N  = 3;
  localparam int D  = 2;
  localparam int PW = PKT_W;

  logic            clock   = 1'b0;
  logic            reset_n = 1'b1;
  logic            squash  = 1'b0;
  logic [N-1:0]    fu_valid = '0;
  logic [N*PW-1:0] fu_packet = '0;
  logic [N-1:0]    fu_ready;
  logic [PW-1:0]   ex_ic_reg;
  logic            ic_busy;

  ex_ic_arbiter #(.N_FU(N), .FIFO_DEPTH(D)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .fu_valid  (fu_valid),
    .fu_packet (fu_packet),
    .fu_ready  (fu_ready),
    .squash    (squash),
    .ex_ic_reg (ex_ic_reg),
    .ic_busy   (ic_busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ex_ic_packet_t mk(input int fu, input int s);
    ex_ic_packet_t p;
    p                   = '0;
    p.valid             = s[0];
    p.rob_idx           = 5'(s);
    p.dest_tag.phys_reg = 6'(fu * 8 + s);
    p.result            = {4'(fu), 28'(s)};
    p.take_branch       = s[1];
    return p;
  endfunction

  task automatic set_pkt(input int i, input ex_ic_packet_t p);
    fu_packet[i*PW +: PW] = p;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: one queue per FU, round-robin pick over queue heads.
  ex_ic_packet_t mq [N][$];
  int            m_rr = 0;
  ex_ic_packet_t m_reg = '0;
  bit            m_rdy [N];
  int            m_w;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n || squash) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr  = 0;
      m_reg = '0;
    end else begin
      for (int i = 0; i < N; i++) m_rdy[i] = (mq[i].size() != D);
      m_w = -1;
      for (int k = 0; k < N; k++) begin
        if (m_w < 0 && mq[(m_rr + k) % N].size() > 0) m_w = (m_rr + k) % N;
      end
      if (m_w >= 0) begin
        m_reg       = mq[m_w].pop_front();
        m_reg.valid = 1'b1;
        m_rr        = (m_w + 1) % N;
      end else begin
        m_reg = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (fu_valid[i] && m_rdy[i]) mq[i].push_back(ex_ic_packet_t'(fu_packet[i*PW +: PW]));
      end
    end
  end

  // Compare process plus a log of every grant seen on the output.
  int            cyc = 0;
  int            g_fu  [$];
  int            g_seq [$];
  int            g_cyc [$];
  ex_ic_packet_t obs;
  logic [N-1:0]  e_rdy;
  logic          e_busy;

  always @(negedge clock) begin
    e_busy = m_reg.valid;
    for (int i = 0; i < N; i++) begin
      e_rdy[i] = reset_n && (mq[i].size() != D);
      if (mq[i].size() > 0) e_busy = 1'b1;
    end
    check("model_ex_ic_reg", 64'(ex_ic_reg), 64'(m_reg));
    check("model_fu_ready",  64'(fu_ready),  64'(e_rdy));
    check("model_ic_busy",   64'(ic_busy),   64'(e_busy));
    obs = ex_ic_packet_t'(ex_ic_reg);
    if (obs.valid) begin
      g_fu.push_back(int'(obs.result[31:28]));
      g_seq.push_back(int'(obs.result[27:0]));
      g_cyc.push_back(cyc);
    end
    cyc++;
  end

  ex_ic_packet_t o;
  int            seq [N];
  bit            rdy_s [N];
  bit            saw_nr2;
  int            mark, end_cyc, n2, bad, gaps, badgap, last2;

  initial begin
    // Reset held with random FU traffic.
    #1 reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      fu_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_pkt(i, mk(i, int'($urandom_range(0, 31))));
      @(negedge clock);
      check("rst_ex_ic_reg", 64'(ex_ic_reg), 64'd0);
      check("rst_fu_ready",  64'(fu_ready),  64'd0);
    end
    fu_valid = '0;
    #2 reset_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(fu_ready), 64'b111);
    check("post_rst_busy",  64'(ic_busy),  64'd0);

    // Contention: all three push on one edge, rr_ptr is 0.
    tick();
    fu_valid = 3'b111;
    for (int i = 0; i < N; i++) set_pkt(i, mk(i, 10 + i));
    tick();
    fu_valid = '0;
    @(negedge clock); o = ex_ic_reg;
    check("cont_e0_valid", 64'(o.valid), 64'd0);
    for (int k = 0; k < N; k++) begin
      @(negedge clock); o = ex_ic_reg;
      check("cont_valid", 64'(o.valid), 64'd1);
      check("cont_fu",    64'(o.result[31:28]), 64'(k));
    end
    @(negedge clock); o = ex_ic_reg;
    check("cont_done_valid", 64'(o.valid), 64'd0);

    // Single FU1 packet.
    tick();
    o = '0;
    o.rob_idx = 5'd5;
    o.dest_tag.phys_reg = 6'd12;
    o.result = {4'd1, 28'd7};
    fu_valid = 3'b010;
    set_pkt(1, o);
    tick();
    fu_valid = '0;
    @(negedge clock); o = ex_ic_reg;
    check("single_e0_valid", 64'(o.valid), 64'd0);
    @(negedge clock); o = ex_ic_reg;
    check("single_valid", 64'(o.valid), 64'd1);
    check("single_rob",   64'(o.rob_idx), 64'd5);
    check("single_phys",  64'(o.dest_tag.phys_reg), 64'd12);
    @(negedge clock); o = ex_ic_reg;
    check("single_e2_valid", 64'(o.valid), 64'd0);

    // Backpressure: all FUs stream, each holding its packet until accepted.
    tick();
    for (int i = 0; i < N; i++) seq[i] = 0;
    saw_nr2 = 1'b0;
    mark = g_fu.size();
    for (int c = 0; c < 15; c++) begin
      fu_valid = 3'b111;
      for (int i = 0; i < N; i++) set_pkt(i, mk(i, seq[i]));
      @(negedge clock);
      for (int i = 0; i < N; i++) rdy_s[i] = fu_ready[i];
      if (!fu_ready[2]) saw_nr2 = 1'b1;
      @(posedge clock); #1;
      for (int i = 0; i < N; i++) if (rdy_s[i]) seq[i]++;
    end
    end_cyc = cyc;
    fu_valid = '0;
    repeat (10) tick();
    check("bp_fu2_not_ready", 64'(saw_nr2), 64'd1);
    n2 = 0; bad = 0; gaps = 0; badgap = 0; last2 = -1;
    for (int k = mark; k < g_fu.size(); k++) begin
      if (g_fu[k] == 2) begin
        if (g_seq[k] != n2) bad++;
        n2++;
        if (g_cyc[k] < end_cyc) begin
          if (last2 >= 0) begin
            gaps++;
            if (g_cyc[k] - last2 != 3) badgap++;
          end
          last2 = g_cyc[k];
        end
      end
    end
    check("bp_fu2_count",    64'(n2), 64'(seq[2]));
    check("bp_fu2_order",    64'(bad), 64'd0);
    check("bp_fu2_gap",      64'(badgap), 64'd0);
    check("bp_fu2_gaps_seen", 64'(gaps >= 3), 64'd1);

    // Squash with FU0 loaded and FU1 pushing on the squash edge.
    fu_valid = 3'b001;
    set_pkt(0, mk(0, 20));
    tick();
    set_pkt(0, mk(0, 21));
    tick();
    fu_valid = 3'b010;
    set_pkt(1, mk(1, 22));
    squash = 1'b1;
    tick();
    squash = 1'b0;
    fu_valid = '0;
    mark = g_fu.size();
    @(negedge clock); o = ex_ic_reg;
    check("sq_valid", 64'(o.valid), 64'd0);
    check("sq_busy",  64'(ic_busy), 64'd0);
    check("sq_ready", 64'(fu_ready), 64'b111);
    repeat (5) tick();
    check("sq_no_stale", 64'(g_fu.size() - mark), 64'd0);

    // Async reset in the middle of a burst.
    fu_valid = 3'b111;
    for (int i = 0; i < N; i++) set_pkt(i, mk(i, 30));
    tick();
    tick();
    o = ex_ic_reg;
    check("ar_pre_valid", 64'(o.valid), 64'd1);
    #2 reset_n = 1'b0;
    fu_valid = '0;
    #1; o = ex_ic_reg;
    check("ar_valid", 64'(o.valid), 64'd0);
    check("ar_ready", 64'(fu_ready), 64'd0);
    check("ar_busy",  64'(ic_busy), 64'd0);
    tick();
    tick();
    #2 reset_n = 1'b1;
    mark = g_fu.size();
    repeat (6) tick();
    check("ar_no_stale", 64'(g_fu.size() - mark), 64'd0);
    check("ar_ready_after", 64'(fu_ready), 64'b111);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
